// File: rtl/noc_tile_loopback_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : noc_tile_loopback_buffer_if
// Purpose  : Flit handshake bundle between a compute tile and its loopback buffer.
// Revision : 1.0
// ============================================================================
interface noc_tile_loopback_buffer_if #(
  parameter int FLIT_WIDTH = 32,
  parameter int CHANNELS   = 2
);
  logic [CHANNELS-1:0][FLIT_WIDTH-1:0] in_flit;
  logic [CHANNELS-1:0]                 in_last;
  logic [CHANNELS-1:0]                 in_valid;
  logic [CHANNELS-1:0]                 in_ready;
  logic [CHANNELS-1:0][FLIT_WIDTH-1:0] out_flit;
  logic [CHANNELS-1:0]                 out_last;
  logic [CHANNELS-1:0]                 out_valid;
  logic [CHANNELS-1:0]                 out_ready;

  // Tile side: produces into the buffer and consumes its replay.
  modport master (
    output in_flit, in_last, in_valid, out_ready,
    input  in_ready, out_flit, out_last, out_valid
  );

  modport slave (
    input  in_flit, in_last, in_valid, out_ready,
    output in_ready, out_flit, out_last, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/noc_tile_loopback_buffer.sv
`default_nettype none
// ============================================================================
// Module   : noc_tile_loopback_buffer
// Purpose  : Per-VC store-and-forward loopback FIFO with cut-through escape.
// Revision : 1.0
// ============================================================================
module noc_tile_loopback_buffer #(
  parameter int FLIT_WIDTH = 32,
  parameter int CHANNELS   = 2,
  parameter int DEPTH      = 16
) (
  input  wire logic                                      clk,
  input  wire logic                                      rst,
  noc_tile_loopback_buffer_if.slave                      bus,
  output logic [CHANNELS-1:0][$clog2(DEPTH+1)-1:0]       pkt_count,
  output logic [CHANNELS-1:0]                            cut_through_seen
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  logic [FLIT_WIDTH:0] r_mem       [CHANNELS][DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr    [CHANNELS];
  logic [PTR_W-1:0]    r_rd_ptr    [CHANNELS];
  logic [CNT_W-1:0]    r_count     [CHANNELS];
  logic [CNT_W-1:0]    r_pkts      [CHANNELS];
  logic [CHANNELS-1:0] r_ct_active;
  logic [CHANNELS-1:0] r_ct_seen;

  logic [FLIT_WIDTH:0] w_head      [CHANNELS];
  logic [CHANNELS-1:0] w_wr;
  logic [CHANNELS-1:0] w_rd;

  always_comb begin
    bus.in_ready  = '0;
    bus.out_flit  = '0;
    bus.out_last  = '0;
    bus.out_valid = '0;
    w_wr          = '0;
    w_rd          = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_head[c]        = r_mem[c][r_rd_ptr[c]];
      bus.in_ready[c]  = !rst && (r_count[c] != C_FULL);
      bus.out_flit[c]  = w_head[c][FLIT_WIDTH-1:0];
      bus.out_last[c]  = w_head[c][FLIT_WIDTH];
      // A stored last flit means the head packet is complete (packets are in order).
      bus.out_valid[c] = (r_count[c] != '0) && ((r_pkts[c] != '0) || r_ct_active[c]);
      w_wr[c]          = bus.in_valid[c] && bus.in_ready[c];
      w_rd[c]          = bus.out_valid[c] && bus.out_ready[c];
    end
  end

  // Flit storage carries no reset: contents are ignored while count is zero.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_wr[c]) begin
        r_mem[c][r_wr_ptr[c]] <= {bus.in_last[c], bus.in_flit[c]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_wr_ptr[c] <= '0;
        r_rd_ptr[c] <= '0;
        r_count[c]  <= '0;
        r_pkts[c]   <= '0;
      end
      r_ct_active <= '0;
      r_ct_seen   <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_wr[c]) begin
          r_wr_ptr[c] <= r_wr_ptr[c] + 1'b1;
        end
        if (w_rd[c]) begin
          r_rd_ptr[c] <= r_rd_ptr[c] + 1'b1;
        end
        r_count[c] <= r_count[c] + CNT_W'(w_wr[c]) - CNT_W'(w_rd[c]);
        r_pkts[c]  <= r_pkts[c] + CNT_W'(w_wr[c] && bus.in_last[c])
                                - CNT_W'(w_rd[c] && bus.out_last[c]);
        // Full of a partial packet: stream it out to break the deadlock.
        if (w_rd[c] && bus.out_last[c]) begin
          r_ct_active[c] <= 1'b0;
        end else if ((r_count[c] == C_FULL) && (r_pkts[c] == '0)) begin
          r_ct_active[c] <= 1'b1;
          r_ct_seen[c]   <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    pkt_count = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      pkt_count[c] = r_pkts[c];
    end
  end

  assign cut_through_seen = r_ct_seen;

endmodule
`default_nettype wire
